// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bundle: instruction-memory request/return plus the decode-facing
// redirect/stall controls and queue output.
interface fetch_prefetch_queue_if #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_target;
    logic               stall;
    logic               need_nop;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_pc_plus_four;
    logic [OCC_W-1:0]   occupancy;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus_four, occupancy,
        input  imem_rdata, redirect, redirect_target, stall, need_nop
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus_four, occupancy,
        output imem_rdata, redirect, redirect_target, stall, need_nop
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// PC sequencer and DEPTH-entry {pc, instr} prefetch FIFO sitting between a one-cycle
// instruction memory and decode, with redirect flush and bubble injection.
module fetch_prefetch_queue #(
    parameter int unsigned        DEPTH        = 4,
    parameter int unsigned        ADDR_W       = 32,
    parameter int unsigned        INSTR_W      = 32,
    parameter logic [ADDR_W-1:0]  INIT_ADDRESS = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR    = INSTR_W'(32'h00000015)
) (
    input logic                    clk,
    input logic                    reset,
    fetch_prefetch_queue_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned CNT_W = OCC_W + 1;

    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  issued_pc_q;
    logic               inflight_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [OCC_W-1:0]   occ_q;
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    logic             pop;
    logic             push;
    logic             issue;
    logic [CNT_W-1:0] credit_used;

    // A pop in this cycle frees its slot for an issue in the same cycle; the returning
    // word then always finds room, so there is no overflow path.
    always_comb begin
        pop  = !reset && !bus.redirect && !bus.stall && !bus.need_nop && (occ_q != '0);
        push = !reset && !bus.redirect && inflight_q;
        credit_used = CNT_W'(occ_q) + CNT_W'(inflight_q) - CNT_W'(pop);
        issue = !reset && !bus.redirect && (credit_used < CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= INIT_ADDRESS;
            issued_pc_q <= '0;
            inflight_q  <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            occ_q       <= '0;
        end else if (bus.redirect) begin
            // Flush queue; the in-flight return (if any) is dropped via push=0.
            pc_q       <= bus.redirect_target;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            if (issue) begin
                pc_q        <= pc_q + ADDR_W'(4);
                issued_pc_q <= pc_q;
            end
            inflight_q <= issue;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= issued_pc_q;
            instr_mem[wr_ptr_q] <= bus.imem_rdata;
        end
    end

    always_comb begin
        bus.imem_req         = issue;
        bus.imem_addr        = pc_q;
        bus.occupancy        = occ_q;
        bus.out_valid        = 1'b0;
        bus.out_instr        = '0;
        bus.out_pc           = '0;
        bus.out_pc_plus_four = '0;
        if (!reset) begin
            if (bus.need_nop) begin
                bus.out_valid = 1'b1;
                bus.out_instr = NOP_INSTR;
            end else if (occ_q != '0) begin
                bus.out_valid        = 1'b1;
                bus.out_instr        = instr_mem[rd_ptr_q];
                bus.out_pc           = pc_mem[rd_ptr_q];
                bus.out_pc_plus_four = pc_mem[rd_ptr_q] + ADDR_W'(4);
            end
        end
    end
endmodule
